timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Programmable down-counting timer; one memory-mapped device behind the system bridge. It is the downstream consumer of the bridge's device address, write-data and per-device write-enable outputs.
- Returns read data to the bridge's per-device read-data input.
- Raises a maskable interrupt request to the CP0 interrupt inputs.
- Two instances are built: DEV0 at 0x7F00-0x7F0B and DEV1 at 0x7F10-0x7F1B.

Parameters:
- CNT_WIDTH, 32, width of PRESET and COUNT registers (bridge data bus is 32 bits; upper bits read as 0 if CNT_WIDTH < 32).

Ports:
- TC_i_Clk  input  1  system clock, rising edge.
- TC_i_Reset_n  input  1  reset; asynchronous, active-low.
- TC_i_Addr  input  32  device address from bridge; only [3:2] decoded.
- TC_i_WEnable  input  1  write strobe from bridge (bridge asserts it only for full-word stores in this device's range).
- TC_i_WData  input  32  write data from bridge.
- TC_o_RData  output  32  combinational read data for TC_i_Addr.
- TC_o_IRQ  output  1  interrupt request, registered.

Behaviour:
Register map, by Addr[3:2]:
- 00 CTRL (R/W). Bit 0 EN, bits [2:1] MODE, bit 3 IM. Other bits read 0.
- 01 PRESET (R/W).
- 10 COUNT (read-only; writes ignored).
- 11 reads 0; writes ignored.

Reset (async, TC_i_Reset_n=0): CTRL=0, PRESET=0, COUNT=0, state=IDLE, pending=0, TC_o_IRQ=0. Reset asserted mid-count aborts immediately; there is no residual IRQ.

Writes: take effect at the rising edge where TC_i_WEnable=1; the FSM sees the new value in the following cycle.

FSM: IDLE, LOAD, CNT, INT.
- IDLE: if EN=1, go to LOAD.
- LOAD: COUNT<=PRESET; go to CNT.
- CNT: if EN=0, go to IDLE and freeze COUNT. Else if COUNT>1, COUNT<=COUNT-1. Else (COUNT is 1 or 0), COUNT<=0, pending<=1, go to INT.
- INT, MODE=00 (one-shot): EN<=0; go to IDLE; pending held.
- INT, MODE=01 (auto-reload): pending<=0; go to LOAD.
- MODE=10 or 11: treated as 00.

Interrupt:
- TC_o_IRQ = pending & IM, registered. It rises on the same edge the FSM enters INT.
- Mode 0: pending cleared by any CTRL write.
- Mode 1: IRQ is a one-cycle pulse.
- Clearing IM masks the output but keeps pending.

Timing:
- First IRQ rises preset+2 edges after the edge that wrote EN=1.
- Mode-1 period is preset+2 cycles.
- PRESET=0 gives INT 2 edges after LOAD.

Collisions:
- A CTRL write on the same edge as INT's EN<=0 wins (the CPU value is kept) and clears pending.
- A PRESET write during CNT does not disturb COUNT; it is used at the next LOAD.
- Writing EN=0 during LOAD or INT returns the FSM to IDLE on the next edge; any pending already set is kept until a CTRL write.

Read data:
- Combinational, no latency; reads have no side effects.
- Address bits outside [3:2] are ignored (the bridge guarantees range).

Test Plan:
1. Reset -> all reads 0, IRQ=0. Assert reset mid-CNT with COUNT=5 -> COUNT=0, IRQ=0 immediately.
2. PRESET=3, then CTRL=0x9 (EN, mode0, IM) at edge E0 -> COUNT 3,2,1,0 after E2..E5; IRQ=1 after E5; CTRL reads 0x8 after E6. IRQ stays 1 until a CTRL write of 0x0, then 0 on the next edge.
3. PRESET=3, CTRL=0xB (mode1, IM) -> IRQ one-cycle pulses at E5, E10, E15; COUNT reloads 3 after E7.
4. Mode0 with CTRL=0x1 (IM=0) -> COUNT reaches 0, IRQ stays 0; then write CTRL=0x8 -> pending cleared by that write, IRQ stays 0.
5. Count running, PRESET=10 at COUNT=6 -> write PRESET=2 -> countdown continues 5,4..., INT unaffected. Mode1 next reload loads 2. CTRL=0x0 written mid-count freezes COUNT.
6. Write 0x1234 to offset 0x8 and 0xC -> COUNT unchanged, offset 0xC reads 0. PRESET=0 with EN -> IRQ 2 edges after LOAD.

Source files
------------

// File: rtl/timer_counter.sv
// Programmable down-counting timer with one-shot / auto-reload modes and a
// maskable, registered interrupt request. Register map decoded on Addr[3:2].
module timer_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic        TC_i_Clk,
   input  logic        TC_i_Reset_n,
   input  logic [31:0] TC_i_Addr,
   input  logic        TC_i_WEnable,
   input  logic [31:0] TC_i_WData,
   output logic [31:0] TC_o_RData,
   output logic        TC_o_IRQ
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_e;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] MODE_RELOAD = 2'b01;

   state_e               state_q, state_d;
   logic                 en_q, en_d;
   logic [1:0]           mode_q, mode_d;
   logic                 im_q, im_d;
   logic [CNT_WIDTH-1:0] preset_q, preset_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 pending_q, pending_d;
   logic                 irq_q, irq_d;
   logic                 wr_ctrl, wr_preset;
   logic                 pend_set;

   assign wr_ctrl   = TC_i_WEnable && (TC_i_Addr[3:2] == ADDR_CTRL);
   assign wr_preset = TC_i_WEnable && (TC_i_Addr[3:2] == ADDR_PRESET);

   // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      en_d      = en_q;
      mode_d    = mode_q;
      im_d      = im_q;
      preset_d  = preset_q;
      count_d   = count_q;
      pending_d = pending_q;
      pend_set  = 1'b0;

      unique case (state_q)
         S_IDLE: if (en_q) state_d = S_LOAD;
         S_LOAD: begin
            if (!en_q) begin
               state_d = S_IDLE;
            end else begin
               count_d = preset_q;
               state_d = S_CNT;
            end
         end
         S_CNT: begin
            if (!en_q) begin
               state_d = S_IDLE;
            end else if (count_q > CNT_WIDTH'(1)) begin
               count_d = count_q - CNT_WIDTH'(1);
            end else begin
               count_d   = '0;
               pending_d = 1'b1;
               pend_set  = 1'b1;
               state_d   = S_INT;
            end
         end
         S_INT: begin
            if (!en_q) begin
               state_d = S_IDLE;
            end else if (mode_q == MODE_RELOAD) begin
               pending_d = 1'b0;
               state_d   = S_LOAD;
            end else begin
               en_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A CPU CTRL write overrides the FSM's EN update and acknowledges any
      // pending interrupt, except one being raised on this very edge.
      if (wr_ctrl) begin
         en_d      = TC_i_WData[0];
         mode_d    = TC_i_WData[2:1];
         im_d      = TC_i_WData[3];
         pending_d = pend_set;
      end
      if (wr_preset) preset_d = TC_i_WData[CNT_WIDTH-1:0];

      irq_d = pending_d & im_d;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge TC_i_Clk or negedge TC_i_Reset_n) begin
      if (!TC_i_Reset_n) begin
         state_q   <= S_IDLE;
         en_q      <= 1'b0;
         mode_q    <= 2'b00;
         im_q      <= 1'b0;
         preset_q  <= '0;
         count_q   <= '0;
         pending_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         mode_q    <= mode_d;
         im_q      <= im_d;
         preset_q  <= preset_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      TC_o_RData = '0;
      unique case (TC_i_Addr[3:2])
         ADDR_CTRL:   TC_o_RData[3:0] = {im_q, mode_q, en_q};
         ADDR_PRESET: TC_o_RData[CNT_WIDTH-1:0] = preset_q;
         ADDR_COUNT:  TC_o_RData[CNT_WIDTH-1:0] = count_q;
         default:     TC_o_RData = '0;
      endcase
   end

   assign TC_o_IRQ = irq_q;

   logic unused_bits;
   assign unused_bits = ^{TC_i_Addr[31:4], TC_i_Addr[1:0], TC_i_WData};

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: table-driven cycle vectors with a
// scoreboard queue, plus hand-written multi-cycle sequences.
module tb_timer_counter;

   localparam logic [31:0] A_CTRL = 32'h7F00;
   localparam logic [31:0] A_PRE  = 32'h7F04;
   localparam logic [31:0] A_CNT  = 32'h7F08;
   localparam logic [31:0] A_RSV  = 32'h7F0C;

   logic        clk;
   logic        rst_n;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [31:0] raddr;
      logic [31:0] exp_rd;
      logic        exp_irq;
      string       name;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] rd;
      logic        irq;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];

   timer_counter #(.CNT_WIDTH(32)) dut (
      .TC_i_Clk    (clk),
      .TC_i_Reset_n(rst_n),
      .TC_i_Addr   (addr),
      .TC_i_WEnable(we),
      .TC_i_WData  (wdata),
      .TC_o_RData  (rdata),
      .TC_o_IRQ    (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic void add_vec(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                                   input logic [31:0] ra, input logic [31:0] erd,
                                   input logic eirq, input string name);
      vecs.push_back('{w, wa, wd, ra, erd, eirq, name});
   endfunction

   // One clock: drive the (optional) write, push the expectation, then after
   // the edge switch the address to the read target and compare.
   task automatic step(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [31:0] ra, input logic [31:0] erd,
                       input logic eirq, input string name);
      exp_t e;
      we    = w;
      addr  = w ? wa : ra;
      wdata = wd;
      sb_q.push_back('{name, erd, eirq});
      @(posedge clk);
      #1;
      we   = 1'b0;
      addr = ra;
      #1;
      e = sb_q.pop_front();
      check({e.name, "_rdata"}, rdata, e.rd);
      check({e.name, "_irq"}, {31'd0, irq}, {31'd0, e.irq});
   endtask

   initial begin
      rst_n = 1'b0;
      we    = 1'b0;
      addr  = A_CTRL;
      wdata = '0;

      // Test 2: one-shot with IM, preset 3
      add_vec(1, A_PRE,  32'd3, A_PRE,  32'd3, 0, "t2_preset");
      add_vec(1, A_CTRL, 32'h9, A_CTRL, 32'h9, 0, "t2_en");
      add_vec(0, A_CNT,  0, A_CNT, 32'd0, 0, "t2_load");
      add_vec(0, A_CNT,  0, A_CNT, 32'd3, 0, "t2_c3");
      add_vec(0, A_CNT,  0, A_CNT, 32'd2, 0, "t2_c2");
      add_vec(0, A_CNT,  0, A_CNT, 32'd1, 0, "t2_c1");
      add_vec(0, A_CNT,  0, A_CNT, 32'd0, 1, "t2_int");
      add_vec(0, A_CTRL, 0, A_CTRL, 32'h8, 1, "t2_en_clr");
      add_vec(0, A_CNT,  0, A_CNT, 32'd0, 1, "t2_irq_held");
      add_vec(1, A_CTRL, 32'h0, A_CTRL, 32'h0, 0, "t2_ack");
      // Test 3: auto-reload pulses every preset+2 cycles
      add_vec(1, A_CTRL, 32'hB, A_CTRL, 32'hB, 0, "t3_en");
      add_vec(0, A_CNT, 0, A_CNT, 32'd0, 0, "t3_load");
      add_vec(0, A_CNT, 0, A_CNT, 32'd3, 0, "t3_a3");
      add_vec(0, A_CNT, 0, A_CNT, 32'd2, 0, "t3_a2");
      add_vec(0, A_CNT, 0, A_CNT, 32'd1, 0, "t3_a1");
      add_vec(0, A_CNT, 0, A_CNT, 32'd0, 1, "t3_pulse1");
      add_vec(0, A_CNT, 0, A_CNT, 32'd0, 0, "t3_pulse1_end");
      add_vec(0, A_CNT, 0, A_CNT, 32'd3, 0, "t3_reload");
      add_vec(0, A_CNT, 0, A_CNT, 32'd2, 0, "t3_b2");
      add_vec(0, A_CNT, 0, A_CNT, 32'd1, 0, "t3_b1");
      add_vec(0, A_CNT, 0, A_CNT, 32'd0, 1, "t3_pulse2");
      add_vec(0, A_CNT, 0, A_CNT, 32'd0, 0, "t3_pulse2_end");
      add_vec(0, A_CNT, 0, A_CNT, 32'd3, 0, "t3_c3");
      add_vec(0, A_CNT, 0, A_CNT, 32'd2, 0, "t3_c2");
      add_vec(0, A_CNT, 0, A_CNT, 32'd1, 0, "t3_c1");
      add_vec(0, A_CNT, 0, A_CNT, 32'd0, 1, "t3_pulse3");
      add_vec(0, A_CNT, 0, A_CNT, 32'd0, 0, "t3_pulse3_end");
      add_vec(1, A_CTRL, 32'h0, A_CNT, 32'd3, 0, "t3_stop_in_load");
      add_vec(0, A_CNT, 0, A_CNT, 32'd3, 0, "t3_frozen1");
      add_vec(0, A_CNT, 0, A_CNT, 32'd3, 0, "t3_frozen2");
      // Test 4: masked one-shot, pending cleared by CTRL write
      add_vec(1, A_CTRL, 32'h1, A_CTRL, 32'h1, 0, "t4_en");
      add_vec(0, A_CNT, 0, A_CNT, 32'd3, 0, "t4_load");
      add_vec(0, A_CNT, 0, A_CNT, 32'd3, 0, "t4_c3");
      add_vec(0, A_CNT, 0, A_CNT, 32'd2, 0, "t4_c2");
      add_vec(0, A_CNT, 0, A_CNT, 32'd1, 0, "t4_c1");
      add_vec(0, A_CNT, 0, A_CNT, 32'd0, 0, "t4_int_masked");
      add_vec(0, A_CTRL, 0, A_CTRL, 32'h0, 0, "t4_en_clr");
      add_vec(1, A_CTRL, 32'h8, A_CTRL, 32'h8, 0, "t4_unmask");
      add_vec(0, A_CTRL, 0, A_CTRL, 32'h8, 0, "t4_no_irq");

      // Test 1 (reset state)
      #1;
      addr = A_CTRL; #1; check("rst_ctrl", rdata, 32'h0);
      addr = A_PRE;  #1; check("rst_preset", rdata, 32'h0);
      addr = A_CNT;  #1; check("rst_count", rdata, 32'h0);
      addr = A_RSV;  #1; check("rst_rsv", rdata, 32'h0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      #6 rst_n = 1'b1;

      foreach (vecs[i])
         step(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr,
              vecs[i].exp_rd, vecs[i].exp_irq, vecs[i].name);

      // Test 5: PRESET rewrite mid-count, used at the next reload
      step(1, A_PRE, 32'd10, A_PRE, 32'd10, 0, "t5_preset10");
      step(1, A_CTRL, 32'hB, A_CTRL, 32'hB, 0, "t5_en");
      step(0, A_CNT, 0, A_CNT, 32'd0, 0, "t5_load");
      for (int k = 10; k >= 6; k--) step(0, A_CNT, 0, A_CNT, 32'(k), 0, "t5_down");
      step(1, A_PRE, 32'd2, A_CNT, 32'd5, 0, "t5_preset_mid");
      for (int k = 4; k >= 1; k--) step(0, A_CNT, 0, A_CNT, 32'(k), 0, "t5_cont");
      step(0, A_CNT, 0, A_CNT, 32'd0, 1, "t5_int1");
      step(0, A_CNT, 0, A_CNT, 32'd0, 0, "t5_reload");
      step(0, A_CNT, 0, A_CNT, 32'd2, 0, "t5_new_preset");
      step(0, A_CNT, 0, A_CNT, 32'd1, 0, "t5_n1");
      step(0, A_CNT, 0, A_CNT, 32'd0, 1, "t5_int2");
      step(0, A_CNT, 0, A_CNT, 32'd0, 0, "t5_reload2");
      step(0, A_CNT, 0, A_CNT, 32'd2, 0, "t5_m2");
      step(1, A_CTRL, 32'h0, A_CNT, 32'd1, 0, "t5_stop");
      step(0, A_CNT, 0, A_CNT, 32'd1, 0, "t5_freeze1");
      step(0, A_CNT, 0, A_CNT, 32'd1, 0, "t5_freeze2");

      // Test 6: ignored writes, PRESET=0, CTRL write colliding with INT
      step(1, A_CNT, 32'h1234, A_CNT, 32'd1, 0, "t6_wr_count");
      step(1, A_RSV, 32'h1234, A_RSV, 32'd0, 0, "t6_wr_rsv");
      step(1, A_PRE, 32'd0, A_PRE, 32'd0, 0, "t6_preset0");
      step(1, A_CTRL, 32'h9, A_CTRL, 32'h9, 0, "t6_en");
      step(0, A_CNT, 0, A_CNT, 32'd1, 0, "t6_load");
      step(0, A_CNT, 0, A_CNT, 32'd0, 0, "t6_cnt0");
      step(0, A_CNT, 0, A_CNT, 32'd0, 1, "t6_int");
      step(1, A_CTRL, 32'h9, A_CTRL, 32'h9, 0, "t6_collide");
      step(0, A_CNT, 0, A_CNT, 32'd0, 0, "t6_reload");
      step(0, A_CNT, 0, A_CNT, 32'd0, 0, "t6_cnt0b");
      step(0, A_CNT, 0, A_CNT, 32'd0, 1, "t6_int2");
      step(0, A_CTRL, 0, A_CTRL, 32'h8, 1, "t6_oneshot_done");
      step(1, A_CTRL, 32'h0, A_CTRL, 32'h0, 0, "t6_ack");

      // Test 1 (reset asserted mid-count)
      step(1, A_PRE, 32'd8, A_PRE, 32'd8, 0, "t1_preset8");
      step(1, A_CTRL, 32'h9, A_CTRL, 32'h9, 0, "t1_en");
      step(0, A_CNT, 0, A_CNT, 32'd0, 0, "t1_load");
      for (int k = 8; k >= 5; k--) step(0, A_CNT, 0, A_CNT, 32'(k), 0, "t1_down");
      rst_n = 1'b0;
      #1;
      addr = A_CNT;  #1; check("t1_rst_count", rdata, 32'h0);
      check("t1_rst_irq", {31'd0, irq}, 32'd0);
      addr = A_CTRL; #1; check("t1_rst_ctrl", rdata, 32'h0);
      addr = A_PRE;  #1; check("t1_rst_preset", rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, A_CNT, 0, A_CNT, 32'd0, 0, "t1_idle_after_rst");

      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
